// File: rtl/fpadd_pkg.sv
// Shared definitions for the half-precision adder result path: default widths,
// status bit positions and the packed result entry stored by the queue.
package fpadd_pkg;

    localparam int SIG_WIDTH = 10;
    localparam int EXP_WIDTH = 5;

    localparam int ST_ZERO     = 0;
    localparam int ST_INF      = 1;
    localparam int ST_INVALID  = 2;
    localparam int ST_TINY     = 3;
    localparam int ST_HUGE     = 4;
    localparam int ST_INEXACT  = 5;
    localparam int ST_HUGEINT  = 6;
    localparam int ST_COMPSPEC = 7;

    typedef struct packed {
        logic [SIG_WIDTH+EXP_WIDTH:0] z;
        logic [ST_COMPSPEC:0]         status;
    } fp_result_t;

endpackage

// File: rtl/fpadd_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module fpadd_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fpadd_result_q.sv
// In-order result queue behind the fp adder. Optional sticky exception flags
// are built when FPADD_STICKY_FLAGS_EN is defined.
module fpadd_result_q
    import fpadd_pkg::*;
#(
    parameter int SIG_WIDTH = fpadd_pkg::SIG_WIDTH,
    parameter int EXP_WIDTH = fpadd_pkg::EXP_WIDTH,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] in_z,
    input  logic [7:0]                   in_status,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0] out_z,
    output logic [7:0]                   out_status,
`ifdef FPADD_STICKY_FLAGS_EN
    input  logic                         sticky_clr,
    output logic [7:0]                   sticky_flags,
`endif
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;
    fp_result_t    wr_entry_s;
    fp_result_t    rd_entry_s;

    // Handshake flags come from registered count only, never from in_valid/out_ready.
    assign in_ready  = (count_r != CW'(DEPTH));
    assign out_valid = (count_r != {CW{1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign count     = count_r;

    assign wr_entry_s.z      = in_z;
    assign wr_entry_s.status = in_status;

    fpadd_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fp_result_t))
    ) u_mem (
        .clk   (clk),
        .we    (push_s & ~reset),
        .waddr (wr_ptr_r),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    // Pointer and occupancy tracking; reset discards the whole queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry is masked to zero whenever the queue is empty.
    always_comb begin
        out_z      = '0;
        out_status = 8'h00;
        if (out_valid) begin
            out_z      = rd_entry_s.z;
            out_status = rd_entry_s.status;
        end else begin
            out_z      = '0;
            out_status = 8'h00;
        end
    end

`ifdef FPADD_STICKY_FLAGS_EN
    logic [7:0] sticky_r;

    // Clear and push in the same cycle leaves just the pushed status.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_r <= 8'h00;
        end else begin
            sticky_r <= (sticky_clr ? 8'h00 : sticky_r) | (push_s ? in_status : 8'h00);
        end
    end

    assign sticky_flags = sticky_r;
`endif

endmodule

// File: tb/tb_fpadd_result_q.sv
// Directed self-checking bench for fpadd_result_q (default DEPTH=4).
module tb_fpadd_result_q;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_z;
    logic [7:0]  in_status;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic [7:0]  out_status;
    logic [2:0]  count;
`ifdef FPADD_STICKY_FLAGS_EN
    logic        sticky_clr;
    logic [7:0]  sticky_flags;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fpadd_result_q dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_z         (in_z),
        .in_status    (in_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_status   (out_status),
`ifdef FPADD_STICKY_FLAGS_EN
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
`endif
        .count        (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_z      = 16'h0000;
        in_status = 8'h00;
`ifdef FPADD_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_total++;
        if ({count, in_ready, out_valid, out_z, out_status} !== {3'd0, 1'b1, 1'b0, 16'h0000, 8'h00})
            $display("FAIL reset_state: got cnt=%0d rdy=%b vld=%b z=%h st=%h", count, in_ready, out_valid, out_z, out_status);
        else n_pass++;
`ifdef FPADD_STICKY_FLAGS_EN
        n_total++;
        if (sticky_flags !== 8'h00) $display("FAIL reset_sticky: got %h expected 00", sticky_flags);
        else n_pass++;
`endif
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_z = 16'h3C00; in_status = 8'h00;
        tick();
        idle();
        n_total++;
        if ({out_valid, out_z, out_status, count} !== {1'b1, 16'h3C00, 8'h00, 3'd1})
            $display("FAIL single_push: got vld=%b z=%h st=%h cnt=%0d expected 1 3c00 00 1", out_valid, out_z, out_status, count);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        idle();
        n_total++;
        if ({out_valid, out_z, count} !== {1'b0, 16'h0000, 3'd0})
            $display("FAIL single_pop: got vld=%b z=%h cnt=%0d expected 0 0000 0", out_valid, out_z, count);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [15:0] zv [4];
        logic [7:0]  sv [4];
        zv = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        sv = '{8'h01, 8'h02, 8'h04, 8'h08};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_z = zv[i]; in_status = sv[i];
            tick();
        end
        idle();
        n_total++;
        if (count !== 3'd4 || in_ready !== 1'b0)
            $display("FAIL full_state: got cnt=%0d rdy=%b expected 4 0", count, in_ready);
        else n_pass++;
        in_valid = 1'b1; in_z = 16'h4500; in_status = 8'h10;
        tick();
        idle();
        n_total++;
        if (count !== 3'd4) $display("FAIL full_reject: got cnt=%0d expected 4", count);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (out_z !== zv[i] || out_status !== sv[i])
                $display("FAIL drain_order[%0d]: got %h/%h expected %h/%h", i, out_z, out_status, zv[i], sv[i]);
            else n_pass++;
            out_ready = 1'b1;
            tick();
            idle();
        end
        n_total++;
        if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL full_drained: got cnt=%0d vld=%b expected 0 0", count, out_valid);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        logic [15:0] zv [4];
        zv = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_z = zv[i]; in_status = 8'h00;
            tick();
        end
        in_valid = 1'b1; in_z = 16'hAAAA; out_ready = 1'b1;
        tick();
        idle();
        n_total++;
        if ({count, in_ready, out_z} !== {3'd3, 1'b1, 16'h2222})
            $display("FAIL full_pop: got cnt=%0d rdy=%b z=%h expected 3 1 2222", count, in_ready, out_z);
        else n_pass++;
        for (int i = 1; i < 4; i++) begin
            n_total++;
            if (out_z !== zv[i]) $display("FAIL full_pop_drain[%0d]: got %h expected %h", i, out_z, zv[i]);
            else n_pass++;
            out_ready = 1'b1;
            tick();
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q [$];
        logic [15:0] v;
        for (int i = 0; i < 2; i++) begin
            v = 16'hA000 + 16'(i);
            in_valid = 1'b1; in_z = v;
            exp_q.push_back(v);
            tick();
        end
        for (int i = 2; i < 10; i++) begin
            v = 16'hA000 + 16'(i);
            n_total++;
            if (out_z !== exp_q[0]) $display("FAIL b2b_head[%0d]: got %h expected %h", i, out_z, exp_q[0]);
            else n_pass++;
            in_valid = 1'b1; in_z = v; out_ready = 1'b1;
            exp_q.push_back(v);
            void'(exp_q.pop_front());
            tick();
            n_total++;
            if (count !== 3'd2) $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count);
            else n_pass++;
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (out_z !== exp_q[0]) $display("FAIL b2b_tail[%0d]: got %h expected %h", i, out_z, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            out_ready = 1'b1;
            tick();
            idle();
        end
    endtask

`ifdef FPADD_STICKY_FLAGS_EN
    task automatic test_sticky();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b1; in_z = 16'h3C00; in_status = 8'h20;
        tick();
        in_status = 8'h04;
        tick();
        idle();
        n_total++;
        if (sticky_flags !== 8'h24) $display("FAIL sticky_or: got %h expected 24", sticky_flags);
        else n_pass++;
        in_valid = 1'b1; in_status = 8'h02; sticky_clr = 1'b1;
        tick();
        idle();
        n_total++;
        if (sticky_flags !== 8'h02) $display("FAIL sticky_clr_push: got %h expected 02", sticky_flags);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        for (int i = 0; i < 8 && out_valid; i++) begin
            out_ready = 1'b1;
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_z = 16'h5000 + 16'(i); in_status = 8'h01;
            tick();
        end
        n_total++;
        if (count !== 3'd3) $display("FAIL mid_prefill: got cnt=%0d expected 3", count);
        else n_pass++;
        in_valid = 1'b1; out_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        n_total++;
        if ({count, out_valid, in_ready, out_z} !== {3'd0, 1'b0, 1'b1, 16'h0000})
            $display("FAIL mid_reset: got cnt=%0d vld=%b rdy=%b z=%h expected 0 0 1 0000", count, out_valid, in_ready, out_z);
        else n_pass++;
`ifdef FPADD_STICKY_FLAGS_EN
        n_total++;
        if (sticky_flags !== 8'h00) $display("FAIL mid_reset_sticky: got %h expected 00", sticky_flags);
        else n_pass++;
`endif
        in_valid = 1'b1; in_z = 16'h7777; in_status = 8'h40;
        tick();
        idle();
        n_total++;
        if ({count, out_z, out_status} !== {3'd1, 16'h7777, 8'h40})
            $display("FAIL post_reset_push: got cnt=%0d z=%h st=%h expected 1 7777 40", count, out_z, out_status);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_single();
        test_full();
        test_full_pop();
        test_back_to_back();
`ifdef FPADD_STICKY_FLAGS_EN
        test_sticky();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpadd_result_q.md
# fpadd_result_q

Result queue directly downstream of the half-precision floating-point adder. It captures each adder result word and its 8-bit status on a valid/ready handshake and buffers it in a small FIFO. It presents results to the consumer in order, and can optionally keep sticky IEEE exception flags across all accepted results. It decouples the combinational adder from a consumer that can stall.

## Interface
- SIG_WIDTH, 10, significand width; matches the adder.
- EXP_WIDTH, 5, exponent width; matches the adder.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  adder result present on in_z/in_status.
- in_ready  output  1  queue can accept this cycle; equals !full.
- in_z  input  SIG_WIDTH+EXP_WIDTH+1  adder result word.
- in_status  input  8  adder status: [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge, [5] inexact, [6] hugeint, [7] compspecific.
- out_valid  output  1  head entry available; equals (count != 0).
- out_ready  input  1  consumer takes the head entry this cycle.
- out_z  output  SIG_WIDTH+EXP_WIDTH+1  head result word; all zeros when out_valid=0.
- out_status  output  8  head status; all zeros when out_valid=0.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- sticky_clr  input  1  synchronous clear of sticky_flags (present only with FPADD_STICKY_FLAGS_EN).
- sticky_flags  output  8  OR of accepted statuses since the last clear (present only with FPADD_STICKY_FLAGS_EN).

## Operation
- push = in_valid && in_ready; pop = out_valid && out_ready.
- On push: write {in_z, in_status} to mem[wr_ptr] and increment wr_ptr modulo DEPTH.
- On pop: increment rd_ptr modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally; full = (count == DEPTH), empty = (count == 0).
- Full: in_ready=0, so no push occurs; a pop in that cycle frees one entry, and in_ready rises the next cycle. There is no same-cycle pass-through.
- Empty: out_valid=0 and out_ready is ignored. A push in that cycle makes out_valid=1 on the next cycle. There is no bypass.
- in_valid while in_ready=0: data is not captured; the upstream holds its data.
- No payload transformation: out_z/out_status are exactly the pushed bits, in FIFO order.
- Reset: wr_ptr=0, rd_ptr=0, count=0, in_ready=1, out_valid=0, out_z=0, out_status=0, sticky_flags=0. Memory contents are not reset.
- A reset asserted mid-stream discards all entries, and any push or pop in that cycle is ignored. Reset takes priority over every other input.

## Timing
- Latency is 1 cycle from an accepted push to out_valid on an empty queue.
- out_z/out_status are a combinational read of mem[rd_ptr], masked by out_valid.
- in_ready and out_valid are functions of registered count only, with no combinational path from in_valid or out_ready.
- Sustained throughput is one result per cycle when out_ready stays high and count ≥ 1.
- sticky_flags is registered and updates the cycle after the push.

## Configuration
- FPADD_STICKY_FLAGS_EN defined:
  - Each cycle, sticky_flags <= (sticky_clr ? 8'h00 : sticky_flags) | (push ? in_status : 8'h00).
  - When clear and push coincide, the result is the pushed status alone.
- FPADD_STICKY_FLAGS_EN undefined: the sticky_clr and sticky_flags ports and the sticky register are omitted entirely.

## Structure
- Shared package fpadd_pkg holds:
  - the status bit index constants (ST_ZERO through ST_COMPSPEC);
  - the parameter defaults (SIG_WIDTH=10, EXP_WIDTH=5);
  - typedef fp_result_t, a packed struct {z, status} used for the memory entry.
- One sub-module, fpadd_fifo_mem, is natural: DEPTH x width register array with write port and asynchronous read port, no reset.
- Pointer, count and handshake logic stay in fpadd_result_q.

## Test plan
- Reset then push 0x3C00/status 0x00: out_valid=1 next cycle, out_z=0x3C00, count=1. Pop: count=0, out_z=0x0000.
- Push 4 results (0x3C00, 0x4000, 0x4200, 0x4400) with out_ready=0: count=4 and in_ready=0. A 5th in_valid with 0x4500 is not captured. Drain reads the four results in order.
- Full queue with in_valid=1 and out_ready=1 for one cycle: pop only, count 4→3, in_ready=1 next cycle.
- Count=2 with simultaneous push and pop for 8 cycles: count stays 2. Order is preserved across pointer wrap-around.
- Sticky (macro on): push status 0x20, then 0x04: sticky_flags=0x24. sticky_clr together with a push of status 0x02: sticky_flags=0x02.
- Reset asserted with count=3 and push/pop both active: next cycle count=0, out_valid=0, in_ready=1, sticky_flags=0.
